msk_frame_sync: RTL and testbench
=================================

Name: msk_frame_sync

Overview:
Synthesizable frame synchronizer placed after the MSK slicer/decoder in the RX chain. It consumes the recovered bit stream (data/valid pair) and searches for a parametrised sync word, tolerating bit errors. It confirms lock over several frames, then strips the sync and outputs payload bits with a start-of-frame marker. It replaces bench-side eyeballing of shifter contents with hardware lock/loss tracking, including MSK polarity-ambiguity correction.

Parameters:
SYNC_W, 32, sync word length in bits (8..64)
SYNC_WORD, 32'h1ACF_FC1D, sync pattern; first transmitted bit is the MSB
FRAME_LEN, 256, total bits per frame including sync; must be > SYNC_W
MAX_ERR, 2, max Hamming distance accepted as a sync match
VERIFY_CNT, 3, consecutive matched syncs (including first detect) required to declare lock
LOSS_CNT, 4, consecutive missed syncs in LOCK that drop lock

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
data_i  in  1  demodulated bit
data_val_i  in  1  data_i qualifier
payload_o  out  1  payload bit, polarity-corrected
payload_val_o  out  1  payload_o qualifier, asserted in LOCK only
sof_o  out  1  high with the first payload bit of each frame
locked_o  out  1  state==LOCK
inverted_o  out  1  stream detected inverted
sync_err_o  out  $clog2(SYNC_W+1)  Hamming distance at last sync check
frame_cnt_o  out  16  frames with a matched sync while in LOCK; wraps

Behaviour:
- Reset: state SEARCH, shift register and fill counter cleared, all outputs 0. Reset mid-frame aborts immediately; outputs are 0 on the cycle after rst is sampled high.
- Nothing advances on cycles where data_val_i=0. Gaps between valid bits have no effect on output content.
- Shift register sr: on each valid bit, sr <= {sr[SYNC_W-2:0], data_i}. Checks use this next value combinationally: d_true = popcount(next_sr ^ SYNC_WORD), d_inv = popcount(next_sr ^ ~SYNC_WORD).
- All outputs are registered: they update 1 clk after the data_val_i cycle that caused them.
- Position counter pos (0..FRAME_LEN-1):
  - pos=0 is the first payload bit.
  - Payload occupies pos 0..FRAME_LEN-SYNC_W-1.
  - Sync occupies the remaining bits; the check is made on the bit arriving at pos=FRAME_LEN-1, then pos wraps to 0.
- SEARCH:
  - No check until SYNC_W valid bits have been received since reset/entry (fill counter saturates).
  - If d_true<=MAX_ERR: match with polarity 0. Else if d_inv<=MAX_ERR (feature enabled): match with polarity 1. True polarity wins if both qualify.
  - On match: latch inverted_o, pos<=0, hits<=1, sync_err_o<=distance. Go to VERIFY, or straight to LOCK if VERIFY_CNT==1.
- VERIFY:
  - At the check position, only the latched polarity is evaluated.
  - Match: hits++ and sync_err_o updated; when hits reaches VERIFY_CNT, go to LOCK.
  - Miss: go to SEARCH with fill counter kept full, so the search resumes on the next bit.
  - No payload is output in VERIFY.
- LOCK:
  - Payload positions: payload_o = data_i ^ inverted_o, payload_val_o=1; sof_o=1 at pos=0.
  - Sync check, match: miss_cnt<=0, frame_cnt_o++.
  - Sync check, miss: miss_cnt++; on reaching LOSS_CNT go to SEARCH, locked_o<=0 on that same update, fill counter kept full.
  - sync_err_o updates at every check in LOCK.
- Entry to SEARCH from any state clears hits and miss_cnt. inverted_o is held until the next detect. frame_cnt_o clears only on rst.
- Popcount uses an adder tree sized for SYNC_W; no pipelining is needed at 200 MHz with a 1-bit input rate ≤ clk.

Optional Feature:
MSK_FSYNC_INV_EN
- Defined: the inverted-polarity search (d_inv) is enabled. An inverted stream locks with inverted_o=1 and its payload is de-inverted.
- Undefined: only d_true is evaluated; inverted_o is tied 0 and inverted streams never lock.

Test Plan:
1. Defaults with FRAME_LEN=64, 5 clean frames (0x1ACFFC1D + 32 random payload bits) -> locked_o rises 1 clk after the last sync bit of frame 3. From frame 4 on, payload_o equals the sent bits, sof_o is on each first bit, frame_cnt_o=1 after the frame-4 sync.
2. Same stream bit-inverted, MSK_FSYNC_INV_EN defined -> inverted_o=1, payload matches the original non-inverted bits. With the macro undefined -> locked_o stays 0.
3. First sync carrying 2 bit errors -> detected, sync_err_o=2. First sync carrying 3 errors -> no detect; lock is acquired starting from the next clean sync.
4. In LOCK, corrupt 3 consecutive syncs then send clean -> locked_o stays 1, frame_cnt_o does not increment on the missed frames. Corrupt 4 consecutive -> locked_o=0 1 clk after the 4th check bit.
5. SYNC_WORD embedded inside payload before the real sync, while in SEARCH -> false detect enters VERIFY, misses at the next check, returns to SEARCH, then reaches LOCK on the true syncs.
6. data_val_i toggling 1/0 every cycle, plus rst pulsed mid-frame -> output bit sequence identical to the continuous case. All outputs are 0 on the cycle after rst; re-lock takes VERIFY_CNT frames.

Source files
------------

// File: rtl/msk_frame_sync.sv
// Bit-serial MSK frame synchronizer: error-tolerant sync search, multi-frame verify, lock/loss tracking, sync stripping.
// Define MSK_FSYNC_INV_EN to also accept the bit-inverted sync word and de-invert the payload.
module msk_frame_sync #(
  parameter int                SYNC_W     = 32,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = SYNC_W'(32'h1ACF_FC1D),
  parameter int                FRAME_LEN  = 256,
  parameter int                MAX_ERR    = 2,
  parameter int                VERIFY_CNT = 3,
  parameter int                LOSS_CNT   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         data_i,
  input  logic                         data_val_i,
  output logic                         payload_o,
  output logic                         payload_val_o,
  output logic                         sof_o,
  output logic                         locked_o,
  output logic                         inverted_o,
  output logic [$clog2(SYNC_W+1)-1:0]  sync_err_o,
  output logic [15:0]                  frame_cnt_o
);

  localparam int ERR_W  = $clog2(SYNC_W + 1);
  localparam int POS_W  = $clog2(FRAME_LEN);
  localparam int FILL_W = $clog2(SYNC_W + 1);
  localparam int HIT_W  = $clog2(VERIFY_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(FRAME_LEN - 1);
  localparam logic [POS_W-1:0]  PAY_END   = POS_W'(FRAME_LEN - SYNC_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_W);
  localparam logic [HIT_W-1:0]  HIT_LOCK  = HIT_W'(VERIFY_CNT);
  localparam logic [MISS_W-1:0] MISS_DROP = MISS_W'(LOSS_CNT);
  localparam logic [ERR_W-1:0]  ERR_MAX   = ERR_W'(MAX_ERR);

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCK   = 2'd2
  } state_t;

  function automatic logic [ERR_W-1:0] popcount(input logic [SYNC_W-1:0] v);
    logic [ERR_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      cnt = cnt + ERR_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t             state_q, state_d;
  // The oldest bit falls off on every shift, so only SYNC_W-1 bits need storing.
  logic [SYNC_W-2:0]  sr_q, sr_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [HIT_W-1:0]   hits_q, hits_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               inv_q, inv_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [15:0]        fcnt_q, fcnt_d;
  logic               pay_q, pay_d;
  logic               pay_val_q, pay_val_d;
  logic               sof_q, sof_d;

  logic [SYNC_W-1:0]  sr_next;
  logic [FILL_W-1:0]  fill_next;
  logic [POS_W-1:0]   pos_next;
  logic [HIT_W-1:0]   hits_inc;
  logic [MISS_W-1:0]  miss_inc;
  logic [ERR_W-1:0]   d_true;
  logic [ERR_W-1:0]   chk_dist;
  logic               match_true;
  logic               match_inv;
  logic               at_check;
  logic               chk_ok;

  assign sr_next    = {sr_q, data_i};
  assign fill_next  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
  assign at_check   = (pos_q == POS_LAST);
  assign pos_next   = at_check ? '0 : pos_q + POS_W'(1);
  assign hits_inc   = hits_q + HIT_W'(1);
  assign miss_inc   = miss_q + MISS_W'(1);
  assign d_true     = popcount(sr_next ^ SYNC_WORD);
  assign match_true = (d_true <= ERR_MAX);

`ifdef MSK_FSYNC_INV_EN
  logic [ERR_W-1:0] d_inv;
  assign d_inv     = popcount(sr_next ^ ~SYNC_WORD);
  assign match_inv = (d_inv <= ERR_MAX);
  // Once a polarity is latched, later checks only look for that polarity.
  assign chk_dist  = inv_q ? d_inv : d_true;
`else
  assign match_inv = 1'b0;
  assign chk_dist  = d_true;
`endif

  assign chk_ok = (chk_dist <= ERR_MAX);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    fill_d    = fill_q;
    pos_d     = pos_q;
    hits_d    = hits_q;
    miss_d    = miss_q;
    inv_d     = inv_q;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    pay_d     = pay_q;
    pay_val_d = 1'b0;
    sof_d     = 1'b0;

    if (data_val_i) begin
      sr_d   = sr_next[SYNC_W-2:0];
      fill_d = fill_next;
      unique case (state_q)
        S_SEARCH: begin
          if (fill_next == FILL_FULL && (match_true || match_inv)) begin
            inv_d   = !match_true;
            err_d   = match_true ? d_true : chk_dist;
`ifdef MSK_FSYNC_INV_EN
            if (!match_true) err_d = d_inv;
`endif
            pos_d   = '0;
            hits_d  = HIT_W'(1);
            state_d = (VERIFY_CNT == 1) ? S_LOCK : S_VERIFY;
          end
        end

        S_VERIFY: begin
          pos_d = pos_next;
          if (at_check) begin
            err_d = chk_dist;
            if (chk_ok) begin
              hits_d = hits_inc;
              if (hits_inc == HIT_LOCK) state_d = S_LOCK;
            end else begin
              hits_d  = '0;
              miss_d  = '0;
              state_d = S_SEARCH;
            end
          end
        end

        S_LOCK: begin
          pos_d = pos_next;
          if (pos_q < PAY_END) begin
            pay_d     = data_i ^ inv_q;
            pay_val_d = 1'b1;
            sof_d     = (pos_q == '0);
          end
          if (at_check) begin
            err_d = chk_dist;
            if (chk_ok) begin
              miss_d = '0;
              fcnt_d = fcnt_q + 16'd1;
            end else if (miss_inc == MISS_DROP) begin
              hits_d  = '0;
              miss_d  = '0;
              state_d = S_SEARCH;
            end else begin
              miss_d = miss_inc;
            end
          end
        end

        default: begin
          hits_d  = '0;
          miss_d  = '0;
          state_d = S_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_SEARCH;
      sr_q      <= '0;
      fill_q    <= '0;
      pos_q     <= '0;
      hits_q    <= '0;
      miss_q    <= '0;
      inv_q     <= 1'b0;
      err_q     <= '0;
      fcnt_q    <= '0;
      pay_q     <= 1'b0;
      pay_val_q <= 1'b0;
      sof_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      fill_q    <= fill_d;
      pos_q     <= pos_d;
      hits_q    <= hits_d;
      miss_q    <= miss_d;
      inv_q     <= inv_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      pay_q     <= pay_d;
      pay_val_q <= pay_val_d;
      sof_q     <= sof_d;
    end
  end

  assign payload_o     = pay_q;
  assign payload_val_o = pay_val_q;
  assign sof_o         = sof_q;
  assign locked_o      = (state_q == S_LOCK);
  assign inverted_o    = inv_q;
  assign sync_err_o    = err_q;
  assign frame_cnt_o   = fcnt_q;

endmodule

// File: tb/tb_msk_frame_sync.sv
// Directed bench for msk_frame_sync with 64-bit frames (32 sync + 32 payload).
// Expectations adapt to whether MSK_FSYNC_INV_EN is defined for the build.
module tb_msk_frame_sync;
  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_i = 1'b0;
  logic        data_val_i = 1'b0;
  logic        payload_o, payload_val_o, sof_o, locked_o, inverted_o;
  logic [5:0]  sync_err_o;
  logic [15:0] frame_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] pay_tab [0:5] = '{32'hA5C3_1E69, 32'h3C96_F00D, 32'h5A0F_C3A5,
                                 32'hDEAD_BEEF, 32'h0123_4567, 32'h9E37_79B9};

  msk_frame_sync #(
    .SYNC_W(32), .SYNC_WORD(SYNC), .FRAME_LEN(64),
    .MAX_ERR(2), .VERIFY_CNT(3), .LOSS_CNT(4)
  ) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .data_val_i(data_val_i),
    .payload_o(payload_o), .payload_val_o(payload_val_o), .sof_o(sof_o),
    .locked_o(locked_o), .inverted_o(inverted_o),
    .sync_err_o(sync_err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_i     = b;
    data_val_i = 1'b1;
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    data_val_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_sync(input logic [31:0] mask, input logic inv, input bit gap);
    for (int i = 31; i >= 0; i--) begin
      send_bit(SYNC[i] ^ mask[i] ^ inv);
      if (gap) idle();
    end
  endtask

  task automatic send_pay(input logic [31:0] w, input logic inv, input bit gap, input bit exp_on);
    for (int i = 31; i >= 0; i--) begin
      send_bit(w[i] ^ inv);
      n_vec++;
      if (exp_on) begin
        if (payload_val_o !== 1'b1 || payload_o !== w[i] || sof_o !== logic'(i == 31)) begin
          n_err++;
          $display("FAIL payload bit%0d: val=%b bit=%b sof=%b, want val=1 bit=%b sof=%b",
                   i, payload_val_o, payload_o, sof_o, w[i], logic'(i == 31));
        end
      end else if (payload_val_o !== 1'b0) begin
        n_err++;
        $display("FAIL payload_quiet bit%0d: payload_val_o=%b want 0", i, payload_val_o);
      end
      if (gap) begin
        idle();
        n_vec++;
        if (payload_val_o !== 1'b0 || sof_o !== 1'b0) begin
          n_err++;
          $display("FAIL gap_cycle: payload_val_o=%b sof_o=%b want 0 0", payload_val_o, sof_o);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({payload_o, payload_val_o, sof_o, locked_o, inverted_o, sync_err_o, frame_cnt_o} !== 27'd0) begin
      n_err++;
      $display("FAIL reset_outputs: lock=%b inv=%b err=%0d fc=%0d pv=%b, want all 0",
               locked_o, inverted_o, sync_err_o, frame_cnt_o, payload_val_o);
    end
  endtask

  // Five clean frames; optional one-cycle gap after each valid bit.
  task automatic run_clean(input logic inv, input bit gap, input bit exp_locks);
    for (int f = 0; f < 5; f++) begin
      send_sync(32'h0, inv, gap);
      n_vec++;
      if (locked_o !== logic'(exp_locks && f >= 2)) begin
        n_err++;
        $display("FAIL lock_after_sync%0d: locked_o=%b want %b", f + 1, locked_o, exp_locks && f >= 2);
      end
      n_vec++;
      if (frame_cnt_o !== ((exp_locks && f >= 3) ? 16'(f - 2) : 16'd0)) begin
        n_err++;
        $display("FAIL frame_cnt_sync%0d: frame_cnt_o=%0d want %0d", f + 1, frame_cnt_o,
                 (exp_locks && f >= 3) ? f - 2 : 0);
      end
      n_vec++;
      if (inverted_o !== logic'(exp_locks && inv)) begin
        n_err++;
        $display("FAIL inverted_sync%0d: inverted_o=%b want %b", f + 1, inverted_o, exp_locks && inv);
      end
      send_pay(pay_tab[f], inv, gap, exp_locks && f >= 2);
    end
  endtask

  task automatic test_clean_lock();
    do_reset();
    run_clean(1'b0, 1'b0, 1'b1);
    n_vec++;
    if (sync_err_o !== 6'd0) begin
      n_err++;
      $display("FAIL clean_sync_err: sync_err_o=%0d want 0", sync_err_o);
    end
  endtask

  task automatic test_inverted();
    do_reset();
`ifdef MSK_FSYNC_INV_EN
    run_clean(1'b1, 1'b0, 1'b1);
`else
    run_clean(1'b1, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_sync_errors();
    do_reset();
    send_sync(32'h8000_0001, 1'b0, 1'b0);
    n_vec++;
    if (sync_err_o !== 6'd2 || locked_o !== 1'b0) begin
      n_err++;
      $display("FAIL err2_detect: sync_err_o=%0d locked_o=%b want 2 0", sync_err_o, locked_o);
    end
    send_pay(pay_tab[0], 1'b0, 1'b0, 1'b0);
    send_sync(32'h0, 1'b0, 1'b0);
    send_pay(pay_tab[1], 1'b0, 1'b0, 1'b0);
    send_sync(32'h0, 1'b0, 1'b0);
    n_vec++;
    if (locked_o !== 1'b1 || sync_err_o !== 6'd0) begin
      n_err++;
      $display("FAIL err2_lock: locked_o=%b sync_err_o=%0d want 1 0", locked_o, sync_err_o);
    end

    do_reset();
    send_sync(32'h8001_0001, 1'b0, 1'b0);
    n_vec++;
    if (sync_err_o !== 6'd0) begin
      n_err++;
      $display("FAIL err3_nodetect: sync_err_o=%0d want 0", sync_err_o);
    end
    for (int f = 0; f < 3; f++) begin
      send_pay(pay_tab[f], 1'b0, 1'b0, 1'b0);
      send_sync(32'h0, 1'b0, 1'b0);
      n_vec++;
      if (locked_o !== logic'(f == 2)) begin
        n_err++;
        $display("FAIL err3_lock_clean%0d: locked_o=%b want %b", f + 1, locked_o, f == 2);
      end
    end
  endtask

  task automatic test_loss();
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send_sync(32'h0, 1'b0, 1'b0);
      send_pay(pay_tab[f], 1'b0, 1'b0, f >= 2);
    end
    for (int k = 0; k < 3; k++) begin
      send_sync(32'h0000_FFFF, 1'b0, 1'b0);
      n_vec++;
      if (locked_o !== 1'b1 || frame_cnt_o !== 16'd1 || sync_err_o !== 6'd16) begin
        n_err++;
        $display("FAIL miss%0d_hold: locked_o=%b frame_cnt_o=%0d sync_err_o=%0d want 1 1 16",
                 k + 1, locked_o, frame_cnt_o, sync_err_o);
      end
      send_pay(pay_tab[k + 2], 1'b0, 1'b0, 1'b1);
    end
    send_sync(32'h0, 1'b0, 1'b0);
    n_vec++;
    if (locked_o !== 1'b1 || frame_cnt_o !== 16'd2 || sync_err_o !== 6'd0) begin
      n_err++;
      $display("FAIL miss_recover: locked_o=%b frame_cnt_o=%0d sync_err_o=%0d want 1 2 0",
               locked_o, frame_cnt_o, sync_err_o);
    end
    send_pay(pay_tab[5], 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send_sync(32'h0000_FFFF, 1'b0, 1'b0);
      n_vec++;
      if (locked_o !== logic'(k < 3) || frame_cnt_o !== 16'd2) begin
        n_err++;
        $display("FAIL loss_miss%0d: locked_o=%b frame_cnt_o=%0d want %b 2",
                 k + 1, locked_o, frame_cnt_o, k < 3);
      end
      send_pay(pay_tab[k], 1'b0, 1'b0, k < 3);
    end
  endtask

  task automatic test_false_detect();
    do_reset();
    send_sync(32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    for (int f = 0; f < 4; f++) begin
      send_sync(32'h0, 1'b0, 1'b0);
      n_vec++;
      if (locked_o !== logic'(f == 3)) begin
        n_err++;
        $display("FAIL false_det_sync%0d: locked_o=%b want %b", f + 1, locked_o, f == 3);
      end
      send_pay(pay_tab[f], 1'b0, 1'b0, f == 3);
    end
  endtask

  task automatic test_gaps_reset();
    do_reset();
    run_clean(1'b0, 1'b1, 1'b1);
    send_sync(32'h0, 1'b0, 1'b1);
    n_vec++;
    if (frame_cnt_o !== 16'd3) begin
      n_err++;
      $display("FAIL gap_frame_cnt: frame_cnt_o=%0d want 3", frame_cnt_o);
    end
    for (int i = 31; i > 21; i--) send_bit(pay_tab[5][i]);
    @(negedge clk);
    rst        = 1'b1;
    data_i     = 1'b1;
    data_val_i = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if ({payload_o, payload_val_o, sof_o, locked_o, inverted_o, sync_err_o, frame_cnt_o} !== 27'd0) begin
      n_err++;
      $display("FAIL midframe_reset: lock=%b pv=%b fc=%0d err=%0d, want all 0",
               locked_o, payload_val_o, frame_cnt_o, sync_err_o);
    end
    @(negedge clk);
    rst        = 1'b0;
    data_val_i = 1'b0;
    for (int f = 0; f < 3; f++) begin
      send_sync(32'h0, 1'b0, 1'b0);
      n_vec++;
      if (locked_o !== logic'(f == 2) || frame_cnt_o !== 16'd0) begin
        n_err++;
        $display("FAIL relock_sync%0d: locked_o=%b frame_cnt_o=%0d want %b 0",
                 f + 1, locked_o, frame_cnt_o, f == 2);
      end
      send_pay(pay_tab[f], 1'b0, 1'b0, f == 2);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_inverted();
    test_sync_errors();
    test_loss();
    test_false_detect();
    test_gaps_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end
endmodule
